// File: rtl/row_softmax_stream_pkg.sv
// Shared definitions for the row-wise softmax engine: FSM encoding, width helpers
// and the elaboration-time generator for the exponential lookup table.
package row_softmax_stream_pkg;

    localparam logic [1:0] ST_LOAD_ENC = 2'd0;
    localparam logic [1:0] ST_EXP_ENC  = 2'd1;
    localparam logic [1:0] ST_DIV_ENC  = 2'd2;
    localparam logic [1:0] ST_OUT_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD = ST_LOAD_ENC,
        ST_EXP  = ST_EXP_ENC,
        ST_DIV  = ST_DIV_ENC,
        ST_OUT  = ST_OUT_ENC
    } state_t;

    localparam int LUT_DEPTH = 256;
    localparam int FIX_FRAC  = 60;

    function automatic int sum_width(input int frac, input int col_max);
        return frac + 1 + $clog2(col_max);
    endfunction

    function automatic int diff_width(input int in_width);
        return in_width + 1;
    endfunction

    // round(2^frac * exp(-k/16)); exp(-1/16) comes from a Taylor series in Q.60,
    // then is raised to the k-th power with rounding at every step.
    function automatic logic [31:0] exp_lut_value(input int frac, input int k);
        logic [127:0] one_v;
        logic [127:0] term_v;
        logic [127:0] ratio_v;
        logic [127:0] acc_v;
        logic [127:0] scaled_v;
        one_v   = 128'd1 << FIX_FRAC;
        term_v  = one_v;
        ratio_v = one_v;
        for (int n = 1; n <= 20; n++) begin
            term_v = term_v / 128'(16 * n);
            if ((n % 2) == 1) begin
                ratio_v = ratio_v - term_v;
            end else begin
                ratio_v = ratio_v + term_v;
            end
        end
        acc_v = one_v;
        for (int j = 0; j < k; j++) begin
            acc_v = ((acc_v * ratio_v) + (one_v >> 1)) >> FIX_FRAC;
        end
        scaled_v = ((acc_v << frac) + (one_v >> 1)) >> FIX_FRAC;
        return scaled_v[31:0];
    endfunction

endpackage

// File: rtl/row_softmax_stream_exp.sv
// Combinational exponential lookup: idx = quantised (max - x) in 1/16 steps,
// e = round(2^FRAC * exp(-idx/16)).
module softmax_exp_lut
    import row_softmax_stream_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic [7:0]    idx,
    output logic [FRAC:0] e
);

    localparam int EW = FRAC + 1;

    logic [FRAC:0] lut_s [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_entry
        assign lut_s[k] = EW'(exp_lut_value(FRAC, k));
    end

    assign e = lut_s[idx];

endmodule

// File: rtl/row_softmax_stream.sv
// Streaming row softmax: buffers one row, subtracts its max, exponentiates via LUT
// and emits exact per-element normalised probabilities over a valid/ready stream.
module row_softmax_stream
    import row_softmax_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int FRAC      = 8,
    parameter int OUT_WIDTH = 16,
    parameter int COL_MAX   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int EW    = FRAC + 1;
    localparam int SW    = sum_width(FRAC, COL_MAX);
    localparam int DW    = diff_width(IN_WIDTH);
    localparam int BW    = (IN_WIDTH > EW) ? IN_WIDTH : EW;
    localparam int AW    = $clog2(COL_MAX);
    localparam int CW    = $clog2(COL_MAX + 1);
    localparam int DCW   = $clog2(EW);
    localparam int SHIFT = FRAC - 4;

    state_t                      state_r;
    logic [BW-1:0]               row_buf_r [COL_MAX];
    logic [CW-1:0]               n_r;
    logic [CW-1:0]               len_r;
    logic [CW-1:0]               ptr_r;
    logic signed [IN_WIDTH-1:0]  max_r;
    logic [SW-1:0]               sum_r;
    logic [DCW-1:0]              div_cnt_r;
    logic [SW-1:0]               rem_r;
    logic [EW-1:0]               q_r;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic [OUT_WIDTH-1:0]        out_data_r;
    logic                        out_last_r;
    logic                        busy_r;

    logic [AW-1:0]               n_addr_s;
    logic [AW-1:0]               ptr_addr_s;
    logic signed [IN_WIDTH-1:0]  elem_s;
    logic [DW-1:0]               diff_s;
    logic [DW-1:0]               diff_sh_s;
    logic [7:0]                  lut_idx_s;
    logic [EW-1:0]               lut_e_s;
    logic [EW-1:0]               e_k_s;
    logic [SW-1:0]               rem_in_s;
    logic                        bit_in_s;
    logic [SW:0]                 trial_s;
    logic                        ge_s;
    logic [SW-1:0]               rem_next_s;
    logic                        accept_s;
    logic                        ptr_at_end_s;

    assign n_addr_s     = n_r[AW-1:0];
    assign ptr_addr_s   = ptr_r[AW-1:0];
    assign accept_s     = in_valid && in_ready_r;
    assign ptr_at_end_s = (ptr_r == (len_r - CW'(1)));

    // Distance from the row max is never negative, so the sign-extended difference
    // can be treated as unsigned and quantised to 1/16 steps.
    assign elem_s    = row_buf_r[ptr_addr_s][IN_WIDTH-1:0];
    assign diff_s    = {max_r[IN_WIDTH-1], max_r} - {elem_s[IN_WIDTH-1], elem_s};
    assign diff_sh_s = diff_s >> SHIFT;
    assign lut_idx_s = (diff_sh_s > DW'(255)) ? 8'hFF : diff_sh_s[7:0];

    softmax_exp_lut #(
        .FRAC (FRAC)
    ) u_exp_lut (
        .idx (lut_idx_s),
        .e   (lut_e_s)
    );

    assign e_k_s = row_buf_r[ptr_addr_s][EW-1:0];

    // Restoring divider step for e_k * 2^FRAC / sum; the first step seeds the
    // remainder with e_k >> 1, which is always below sum.
    always_comb begin
        rem_in_s   = rem_r;
        bit_in_s   = 1'b0;
        if (div_cnt_r == DCW'(0)) begin
            rem_in_s = SW'(e_k_s[EW-1:1]);
            bit_in_s = e_k_s[0];
        end else begin
            rem_in_s = rem_r;
            bit_in_s = 1'b0;
        end
        trial_s    = {rem_in_s, bit_in_s};
        ge_s       = (trial_s >= {1'b0, sum_r});
        rem_next_s = trial_s[SW-1:0];
        if (ge_s) begin
            rem_next_s = SW'(trial_s - {1'b0, sum_r});
        end else begin
            rem_next_s = trial_s[SW-1:0];
        end
    end

    // Row buffer: raw scores while loading, overwritten by exponentials in EXP
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_LOAD) && accept_s) begin
            row_buf_r[n_addr_s] <= BW'(in_data);
        end else if (!rst && (state_r == ST_EXP)) begin
            row_buf_r[ptr_addr_s] <= BW'(lut_e_s);
        end
    end

    // Control FSM, max tracker, exponential accumulator, divider and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            n_r         <= '0;
            len_r       <= '0;
            ptr_r       <= '0;
            max_r       <= '0;
            sum_r       <= '0;
            div_cnt_r   <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        n_r    <= n_r + CW'(1);
                        busy_r <= 1'b1;
                        if ((n_r == CW'(0)) || ($signed(in_data) > max_r)) begin
                            max_r <= in_data;
                        end
                        // A full buffer closes the row even without in_last.
                        if (in_last || (n_r == CW'(COL_MAX - 1))) begin
                            len_r      <= n_r + CW'(1);
                            ptr_r      <= '0;
                            in_ready_r <= 1'b0;
                            state_r    <= ST_EXP;
                        end
                    end
                end
                ST_EXP: begin
                    sum_r <= sum_r + SW'(lut_e_s);
                    if (ptr_at_end_s) begin
                        ptr_r     <= '0;
                        div_cnt_r <= '0;
                        state_r   <= ST_DIV;
                    end else begin
                        ptr_r <= ptr_r + CW'(1);
                    end
                end
                ST_DIV: begin
                    rem_r     <= rem_next_s;
                    q_r       <= {q_r[EW-2:0], ge_s};
                    div_cnt_r <= div_cnt_r + DCW'(1);
                    if (div_cnt_r == DCW'(FRAC)) begin
                        state_r <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= OUT_WIDTH'(q_r);
                        out_last_r  <= ptr_at_end_s;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (ptr_at_end_s) begin
                            n_r        <= '0;
                            max_r      <= '0;
                            sum_r      <= '0;
                            ptr_r      <= '0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_LOAD;
                        end else begin
                            ptr_r     <= ptr_r + CW'(1);
                            div_cnt_r <= '0;
                            state_r   <= ST_DIV;
                        end
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: doc/row_softmax_stream.md
# row_softmax_stream

Sequential, parametrised row-wise softmax engine for the attention datapath; successor to the combinational whole-matrix softmax. Accepts one signed fixed-point score per cycle over a valid/ready stream, buffers one row, subtracts the row maximum, applies a LUT exponential and exact per-element normalisation. Emits one unsigned probability per handshake, with row framing via `last`. Row length is run-time (≤ COL_MAX), so one instance serves any sequence length.

## Interface
- `IN_WIDTH`, 16: input score width, signed two's complement.
- `FRAC`, 8: fractional bits of input and output (Q(IN_WIDTH-FRAC).FRAC); must be ≥ 4.
- `OUT_WIDTH`, 16: output width; must be ≥ FRAC+1.
- `COL_MAX`, 64: maximum row length, i.e. row buffer depth.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in IN_WIDTH: score.
- `in_valid` in 1: score valid.
- `in_last` in 1: final score of the row.
- `in_ready` out 1: high only in LOAD.
- `out_data` out OUT_WIDTH: probability, zero-extended, ≤ 2^FRAC.
- `out_valid` out 1.
- `out_last` out 1: final probability of the row.
- `out_ready` in 1.
- `busy` out 1: high in any state other than LOAD-with-empty-buffer.

## Operation
- States: LOAD → EXP → DIV ⇄ OUT → LOAD.
- LOAD
  - Each `in_valid && in_ready` writes `buf[n]` and increments n.
  - Running signed max: the first element initialises it.
  - Leave LOAD when `in_last` is accepted or the COL_MAX-th element is accepted (forced end of row; `in_last` is not required). Set N = n.
- EXP, one element per cycle, i = 0..N-1
  - d = max − buf[i], computed in IN_WIDTH+1 bits, always ≥ 0.
  - idx = min(255, d >> (FRAC−4)).
  - e = LUT[idx], where LUT[k] = round(2^FRAC · exp(−k/16)), width FRAC+1; LUT[0] = 2^FRAC.
  - Write e back to `buf[i]`; sum += e.
  - sum width is FRAC+1+clog2(COL_MAX). sum ≥ 2^FRAC, so division by zero cannot occur.
- DIV: restoring division q = floor(e_k · 2^FRAC / sum), FRAC+1 iterations, one bit per cycle. q ≤ 2^FRAC, so no saturation is needed.
- OUT
  - Present q with `out_valid` = 1 and `out_last` = (k == N−1).
  - On handshake: k++. Go to DIV if k < N; otherwise clear n, max and sum and go to LOAD.
- `out_data`, `out_last` and `out_valid` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. State LOAD, n=0, sum=0.
- Input throughput: 1 element/cycle in LOAD. `in_ready` drops the cycle after the last-accept edge.
- EXP takes exactly N cycles. Each DIV takes exactly FRAC+1 cycles.
- First `out_valid` rises N+FRAC+2 edges after the edge that accepted the row's last element.
- After an output handshake, the next `out_valid` rises FRAC+2 edges later.
- `in_ready` rises on the edge of the final output handshake, so back-to-back rows have no idle cycle.
- `rst` mid-row, in any state, discards the row. Next cycle all outputs are at reset values. No partial output is emitted.
- `in_valid` high outside LOAD is ignored: `in_ready` = 0, and data is not consumed.

## Structure
- Shared package
  - Exp LUT contents (256 × (FRAC+1)) generated as a constant function of FRAC.
  - State encoding localparams.
  - Width helpers: sum width, diff width.
- One sub-module: `softmax_exp_lut`. Combinational: idx[7:0] → e[FRAC:0].
- Divider, max tracker and FSM stay inline. Row buffer is one COL_MAX × max(IN_WIDTH, FRAC+1) register array.

## Test plan
- 8 × 0x0100, `in_last` on 8th, defaults:
  - outputs 8 × 0x0020 (floor(65536/2048)), `out_last` only on the 8th;
  - first `out_valid` 18 cycles after last accept.
- Single element 0x7FFF with `in_last`: one output 0x0100, `out_last`=1, `out_valid` 11 edges after accept.
- Row [0x0100, 0x0000]:
  - e = 256, 94; sum 350;
  - outputs 187 (0x00BB) then 68 (0x0044).
- Row [0x0000, 0xF000] (−16.0): idx clips to 255, e = 0; outputs 0x0100 then 0x0000.
- Backpressure: hold `out_ready`=0 for 20 cycles on output 0 of test 1.
  - `out_data`=0x0020 and `out_valid`=1 stay stable; `in_ready`=0 throughout.
  - Release: the remaining 7 outputs follow at FRAC+2 spacing.
- COL_MAX=8, stream 10 elements without `in_last`, the 10th with `in_last`:
  - first row has 8 outputs, `out_last` on the 8th;
  - elements 9–10 form the second row.
  - Separately, assert `rst` during EXP: `in_ready`=1 and `out_valid`=0 the next cycle, and no outputs are produced.
